// File: rtl/serial_add_ctrl_if.sv
// Handshake and data bundle between the lab top level and the bit-serial adder.
// The master drives the request and operands; the slave returns the status and the result.
interface serial_add_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, sub, a, b, cin,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, sub, a, b, cin,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract sequencer: a single full-adder slice is stepped LSB-first,
// one bit per clock, and the result is returned with a one-cycle done pulse.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    serial_add_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] opa, opb, sum_r;
    logic [CNT_W-1:0] cnt;
    logic             carry, cout_r, ovf_r;
    logic             load, step, last;
    logic             fa_s, fa_cout;

    full_adder u_fa (
        .a   (opa[0]),
        .b   (opb[0]),
        .cin (carry),
        .s   (fa_s),
        .cout(fa_cout)
    );

    assign last = (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // DONE accepts a new request just like IDLE so a held start runs back-to-back
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = RUN;
                    load      = 1'b1;
                end
            end
            RUN: begin
                step = 1'b1;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                if (bus.start) begin
                    state_nxt = RUN;
                    load      = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // On the MSB step the carry FF holds the carry into the MSB, so ovf needs no extra register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opa    <= '0;
            opb    <= '0;
            sum_r  <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else if (load) begin
            opa    <= bus.a;
            opb    <= bus.sub ? ~bus.b : bus.b;
            carry  <= bus.sub | bus.cin;
            cnt    <= '0;
            sum_r  <= '0;
        end else if (step) begin
            sum_r  <= {fa_s, sum_r[WIDTH-1:1]};
            opa    <= {1'b0, opa[WIDTH-1:1]};
            opb    <= {1'b0, opb[WIDTH-1:1]};
            carry  <= fa_cout;
            cnt    <= cnt + 1'b1;
            if (last) begin
                cout_r <= fa_cout;
                ovf_r  <= carry ^ fa_cout;
            end
        end
    end

    assign bus.busy = (state == RUN);
    assign bus.done = (state == DONE);
    assign bus.sum  = sum_r;
    assign bus.cout = cout_r;
    assign bus.ovf  = ovf_r;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: directed scenarios plus random operations
// compared against a plain-arithmetic model of add/subtract with carry and signed overflow.
module tb_serial_add_ctrl;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    serial_add_ctrl_if #(.WIDTH(W)) bus ();

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // returns {ovf, cout, sum}
    function automatic logic [W+1:0] model(input logic s, input logic [W-1:0] x,
                                           input logic [W-1:0] y, input logic ci);
        logic [W-1:0] bo;
        logic [W:0]   full;
        logic         c0;
        logic         ov;
        bo   = s ? ~y : y;
        c0   = s ? 1'b1 : ci;
        full = {1'b0, x} + {1'b0, bo} + {{W{1'b0}}, c0};
        ov   = (x[W-1] == bo[W-1]) && (full[W-1] != x[W-1]);
        return {ov, full[W], full[W-1:0]};
    endfunction

    task automatic run_op(input logic s, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic ci, input string tag);
        logic [W+1:0] e;
        e = model(s, x, y, ci);
        @(negedge clk);
        bus.start = 1'b1; bus.sub = s; bus.a = x; bus.b = y; bus.cin = ci;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
        bus.cin   = 1'($urandom);
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            chk({tag, ".busy"}, 32'(bus.busy), 32'd1);
            chk({tag, ".nodone"}, 32'(bus.done), 32'd0);
        end
        @(negedge clk);
        chk({tag, ".done"}, 32'(bus.done), 32'd1);
        chk({tag, ".busy_off"}, 32'(bus.busy), 32'd0);
        chk({tag, ".sum"}, 32'(bus.sum), 32'(e[W-1:0]));
        chk({tag, ".cout"}, 32'(bus.cout), 32'(e[W]));
        chk({tag, ".ovf"}, 32'(bus.ovf), 32'(e[W+1]));
        @(negedge clk);
        chk({tag, ".done_once"}, 32'(bus.done), 32'd0);
        chk({tag, ".sum_hold"}, 32'(bus.sum), 32'(e[W-1:0]));
    endtask

    initial begin
        logic [W+1:0] e;
        int           ndone;
        logic [W-1:0] dsum;

        bus.start = 1'b0; bus.sub = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst.busy", 32'(bus.busy), 32'd0);
        chk("rst.done", 32'(bus.done), 32'd0);
        chk("rst.sum", 32'(bus.sum), 32'd0);
        chk("rst.cout", 32'(bus.cout), 32'd0);
        chk("rst.ovf", 32'(bus.ovf), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle.busy", 32'(bus.busy), 32'd0);
        chk("idle.done", 32'(bus.done), 32'd0);

        // directed arithmetic cases
        run_op(1'b0, 8'h35, 8'h4A, 1'b0, "add_35_4a");
        run_op(1'b0, 8'hFF, 8'h01, 1'b0, "add_ff_01");
        run_op(1'b0, 8'h7F, 8'h01, 1'b0, "add_7f_01");
        run_op(1'b1, 8'h10, 8'h20, 1'b1, "sub_10_20");
        run_op(1'b1, 8'h80, 8'h01, 1'b0, "sub_80_01");
        run_op(1'b0, 8'hFF, 8'hFF, 1'b1, "add_ff_ff_c");
        run_op(1'b0, 8'h00, 8'h00, 1'b0, "add_zero");
        run_op(1'b1, 8'h00, 8'h00, 1'b0, "sub_zero");
        run_op(1'b0, 8'h80, 8'h80, 1'b0, "add_80_80");

        // start during RUN is ignored
        @(negedge clk);
        bus.start = 1'b1; bus.sub = 1'b0; bus.a = 8'h01; bus.b = 8'h01; bus.cin = 1'b0;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        bus.start = 1'b1; bus.a = 8'hAA; bus.b = 8'h55;
        @(posedge clk);
        #1 bus.start = 1'b0;
        ndone = 0;
        dsum  = '0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.done) begin
                ndone++;
                dsum = bus.sum;
            end
        end
        chk("ign.ndone", 32'(ndone), 32'd1);
        chk("ign.sum", 32'(dsum), 32'h02);
        chk("ign.idle", 32'(bus.busy), 32'd0);

        // level-held start: back-to-back operations
        e = model(1'b0, 8'h12, 8'h34, 1'b0);
        @(negedge clk);
        bus.start = 1'b1; bus.sub = 1'b0; bus.a = 8'h12; bus.b = 8'h34; bus.cin = 1'b0;
        for (int c = 0; c < 40; c++) begin
            logic exp_done, exp_busy;
            @(negedge clk);
            exp_done = (c <= 35) && (c % 9 == 8);
            exp_busy = (c <= 35) && !exp_done;
            chk($sformatf("held.done%0d", c), 32'(bus.done), 32'(exp_done));
            chk($sformatf("held.busy%0d", c), 32'(bus.busy), 32'(exp_busy));
            if (exp_done) chk($sformatf("held.sum%0d", c), 32'(bus.sum), 32'(e[W-1:0]));
            if (c == 29) bus.start = 1'b0;
        end

        // asynchronous reset mid-RUN after a result with cout=1, ovf=1
        run_op(1'b1, 8'h80, 8'h01, 1'b0, "pre_rst");
        @(negedge clk);
        bus.start = 1'b1; bus.sub = 1'b0; bus.a = 8'h5A; bus.b = 8'h11; bus.cin = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst.busy", 32'(bus.busy), 32'd0);
        chk("arst.done", 32'(bus.done), 32'd0);
        chk("arst.sum", 32'(bus.sum), 32'd0);
        chk("arst.cout", 32'(bus.cout), 32'd0);
        chk("arst.ovf", 32'(bus.ovf), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus.done || bus.busy) ndone++;
        end
        chk("arst.quiet", 32'(ndone), 32'd0);
        run_op(1'b0, 8'h03, 8'h04, 1'b0, "post_rst");

        // random operations
        for (int i = 0; i < 60; i++)
            run_op(1'($urandom), W'($urandom), W'($urandom), 1'($urandom),
                   $sformatf("rnd%0d", i));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
